// File: rtl/multi_digit_overlay.sv
// multi_digit_overlay: overlays NUM_DIGITS BCD glyphs (8x16 font, SCALE-magnified) on a pixel stream.
// Latency: draw_on is registered 2 cycles after x/y. Results are committed to the screen only on frame_start.
// Backpressure: result_ready = pending register empty. A second result waits until frame_start drains pending.
// Ports: clk/rst (sync, active-high); x/y pixel position; frame_start frame pulse;
//        result_valid/result_ready/result_digits result handshake (MS nibble = leftmost digit);
//        draw_on glyph pixel; stale = no new result for STALE_FRAMES frames.
module multi_digit_overlay #(
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int NUM_DIGITS   = 2,
  parameter int SCALE        = 4,
  parameter int START_X      = 32,
  parameter int START_Y      = 32,
  parameter int DIGIT_GAP    = 8,
  parameter int STALE_FRAMES = 60,
  parameter int LZ_BLANK     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic                    frame_start,
  input  logic                    result_valid,
  output logic                    result_ready,
  input  logic [4*NUM_DIGITS-1:0] result_digits,
  output logic                    draw_on,
  output logic                    stale
);
  localparam int SHIFT = $clog2(SCALE);
  localparam int PITCH = 8*SCALE + DIGIT_GAP;
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [10:0] BW11 = 11'(8*SCALE);
  localparam logic [10:0] BH11 = 11'(16*SCALE);
  localparam logic [10:0] SY11 = 11'(START_Y);
  localparam logic [10:0] HV11 = 11'(H_VISIBLE);
  localparam logic [10:0] VV11 = 11'(V_VISIBLE);

  // 8x16 digit font; row 0 in the top byte, bit 7 of each byte is the leftmost column.
  function automatic logic [7:0] glyph_row(input logic [3:0] code, input logic [3:0] row);
    logic [127:0] g;
    case (code)
      4'h0:    g = 128'h003C_6666_6E76_6666_6666_6666_3C00_0000;
      4'h1:    g = 128'h0018_3878_1818_1818_1818_1818_7E00_0000;
      4'h2:    g = 128'h003C_6606_060C_1830_6060_667E_0000_0000;
      4'h3:    g = 128'h003C_6606_061C_0606_0606_663C_0000_0000;
      4'h4:    g = 128'h000C_1C3C_6CCC_FF0C_0C0C_0C0C_1E00_0000;
      4'h5:    g = 128'h007E_6060_607C_0606_0606_663C_0000_0000;
      4'h6:    g = 128'h003C_6060_607C_6666_6666_663C_0000_0000;
      4'h7:    g = 128'h007E_6606_0C18_1830_3030_3030_0000_0000;
      4'h8:    g = 128'h003C_6666_663C_6666_6666_663C_0000_0000;
      4'h9:    g = 128'h003C_6666_663E_0606_0606_0C38_0000_0000;
      4'hA:    g = 128'h0000_0000_0000_007E_7E00_0000_0000_0000;
      default: g = '0;
    endcase
    return g[{4'd15 - row, 3'b000} +: 8];
  endfunction

  // ---------------- result handshake and frame-synchronous commit ----------------
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] display;
  logic                    pend_full;
  logic [7:0]              stale_cnt;
  logic [7:0]              cnt_inc;
  logic                    xfer;

  assign result_ready = !pend_full;
  assign xfer         = result_valid && !pend_full;
  assign cnt_inc      = (stale_cnt == 8'(STALE_FRAMES)) ? stale_cnt : stale_cnt + 8'd1;

  // A transfer in a frame_start cycle only lands in pending (pend_full was 0),
  // so it is shown from the next frame_start onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      pending   <= '0;
      display   <= '1;
      stale_cnt <= 8'd0;
      stale     <= 1'b0;
    end else begin
      if (frame_start) begin
        if (pend_full) begin
          display   <= pending;
          pend_full <= 1'b0;
          stale_cnt <= 8'd0;
          stale     <= 1'b0;
        end else begin
          stale_cnt <= cnt_inc;
          stale     <= (cnt_inc == 8'(STALE_FRAMES));
        end
      end
      if (xfer) begin
        pending   <= result_digits;
        pend_full <= 1'b1;
      end
    end
  end

  // ---------------- stage 1: box hit and glyph coordinates ----------------
  logic [10:0]           x11, y11, oy;
  logic                  y_in;
  logic [NUM_DIGITS-1:0] box_hit;
  logic [10:0]           ox [NUM_DIGITS];

  assign x11  = {1'b0, x};
  assign y11  = {1'b0, y};
  assign oy   = y11 - SY11;
  assign y_in = (y11 >= SY11) && (oy < BH11) && (y11 < VV11);

  // Offsets are only meaningful when the lower-bound compare holds; ox < width
  // avoids forming base+width, so no wrap at large START_X.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_box
    localparam logic [10:0] BX = 11'(START_X + k*PITCH);
    assign ox[k]      = x11 - BX;
    assign box_hit[k] = (x11 >= BX) && (ox[k] < BW11);
  end

  logic          hit_c;
  logic [IW-1:0] idx_c;
  logic [2:0]    col_c;
  logic [3:0]    row_c;

  always_comb begin
    hit_c = y_in && (x11 < HV11) && (|box_hit);
    idx_c = '0;
    col_c = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (box_hit[k]) begin
        idx_c = IW'(k);
        col_c = 3'(ox[k] >> SHIFT);
      end
    end
    row_c = 4'(oy >> SHIFT);
  end

  logic          s1_hit;
  logic [IW-1:0] s1_idx;
  logic [3:0]    s1_row;
  logic [2:0]    s1_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit <= 1'b0;
      s1_idx <= '0;
      s1_row <= 4'd0;
      s1_col <= 3'd0;
    end else begin
      s1_hit <= hit_c;
      s1_idx <= idx_c;
      s1_row <= row_c;
      s1_col <= col_c;
    end
  end

  // ---------------- stage 2: effective code and font bit ----------------
  logic [3:0] eff_code [NUM_DIGITS];
  logic       lz_lead;
  logic [3:0] sel_code;
  logic [7:0] glyph_bits;

  // Leading zeros blank until the first nonzero code; the rightmost digit always shows.
  always_comb begin
    lz_lead = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      eff_code[k] = display[4*(NUM_DIGITS-1-k) +: 4];
      if (eff_code[k] != 4'd0) lz_lead = 1'b0;
      else if (LZ_BLANK != 0 && lz_lead && k != NUM_DIGITS-1) eff_code[k] = 4'hF;
      if (stale) eff_code[k] = 4'hA;
    end
  end

  always_comb begin
    sel_code = 4'hF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (s1_idx == IW'(k)) sel_code = eff_code[k];
    end
    glyph_bits = glyph_row(sel_code, s1_row);
  end

  always_ff @(posedge clk) begin
    if (rst) draw_on <= 1'b0;
    else     draw_on <= s1_hit && glyph_bits[3'd7 - s1_col];
  end
endmodule

// File: tb/tb_multi_digit_overlay.sv
// tb_multi_digit_overlay: exercises the digit overlay with directed sequences, a pixel table and random traffic.
// Every cycle compares result_ready, stale and draw_on against an arithmetic screen model.
// Ends with a single summary line.
module tb_multi_digit_overlay;
  localparam int NUM_DIGITS   = 2;
  localparam int SCALE        = 8;
  localparam int START_X      = 32;
  localparam int START_Y      = 32;
  localparam int DIGIT_GAP    = 8;
  localparam int STALE_FRAMES = 3;
  localparam int H_VISIBLE    = 640;
  localparam int V_VISIBLE    = 480;
  localparam int LZ_BLANK     = 1;
  localparam int PITCH        = 8*SCALE + DIGIT_GAP;

  localparam logic [127:0] FONT [11] = '{
    128'h003C_6666_6E76_6666_6666_6666_3C00_0000,
    128'h0018_3878_1818_1818_1818_1818_7E00_0000,
    128'h003C_6606_060C_1830_6060_667E_0000_0000,
    128'h003C_6606_061C_0606_0606_663C_0000_0000,
    128'h000C_1C3C_6CCC_FF0C_0C0C_0C0C_1E00_0000,
    128'h007E_6060_607C_0606_0606_663C_0000_0000,
    128'h003C_6060_607C_6666_6666_663C_0000_0000,
    128'h007E_6606_0C18_1830_3030_3030_0000_0000,
    128'h003C_6666_663C_6666_6666_663C_0000_0000,
    128'h003C_6666_663E_0606_0606_0C38_0000_0000,
    128'h0000_0000_0000_007E_7E00_0000_0000_0000
  };

  typedef struct {
    int px;
    int py;
    int want;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst, frame_start, result_valid, result_ready, draw_on, stale;
  logic [9:0]              x, y;
  logic [4*NUM_DIGITS-1:0] result_digits;

  multi_digit_overlay #(
    .H_VISIBLE(H_VISIBLE), .V_VISIBLE(V_VISIBLE), .NUM_DIGITS(NUM_DIGITS), .SCALE(SCALE),
    .START_X(START_X), .START_Y(START_Y), .DIGIT_GAP(DIGIT_GAP),
    .STALE_FRAMES(STALE_FRAMES), .LZ_BLANK(LZ_BLANK)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(frame_start),
    .result_valid(result_valid), .result_ready(result_ready), .result_digits(result_digits),
    .draw_on(draw_on), .stale(stale)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: what the screen should show, as plain integers.
  int m_disp [NUM_DIGITS];
  int m_pend [NUM_DIGITS];
  bit m_full = 1'b0;
  int m_cnt  = 0;
  bit pred_prev = 1'b0;

  task automatic check(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int shown_code(int d);
    bit all_zero;
    if (m_cnt >= STALE_FRAMES) return 10;
    all_zero = 1'b1;
    for (int j = 0; j <= d; j++) if (m_disp[j] != 0) all_zero = 1'b0;
    if (LZ_BLANK != 0 && all_zero && d < NUM_DIGITS-1) return 15;
    return m_disp[d];
  endfunction

  function automatic bit model_pix(int px, int py);
    int bx, col, row, code;
    if (px >= H_VISIBLE || py >= V_VISIBLE) return 1'b0;
    if (py < START_Y || py >= START_Y + 16*SCALE) return 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      bx = START_X + d*PITCH;
      if (px >= bx && px < bx + 8*SCALE) begin
        col  = (px - bx) / SCALE;
        row  = (py - START_Y) / SCALE;
        code = shown_code(d);
        if (code > 10) return 1'b0;
        return FONT[code][127 - 8*row - col];
      end
    end
    return 1'b0;
  endfunction

  task automatic model_edge(bit r, bit fs, bit v, logic [4*NUM_DIGITS-1:0] dig);
    bit was_empty;
    if (r) begin
      m_full = 1'b0;
      m_cnt  = 0;
      foreach (m_disp[d]) m_disp[d] = 15;
      return;
    end
    was_empty = !m_full;
    if (fs && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
      m_cnt  = 0;
    end else if (fs && m_cnt < STALE_FRAMES) begin
      m_cnt++;
    end
    if (v && was_empty) begin
      foreach (m_pend[d]) m_pend[d] = int'((dig >> (4*(NUM_DIGITS-1-d))) & 8'h0F);
      m_full = 1'b1;
    end
  endtask

  // One clock: drive inputs, step the model, compare all outputs.
  task automatic cycle(bit r, bit fs, bit v, logic [4*NUM_DIGITS-1:0] dig, int px, int py);
    bit exp_draw;
    rst = r; frame_start = fs; result_valid = v; result_digits = dig;
    x = 10'(px); y = 10'(py);
    @(posedge clk); #1;
    model_edge(r, fs, v, dig);
    exp_draw  = r ? 1'b0 : pred_prev;
    pred_prev = r ? 1'b0 : model_pix(px, py);
    check("ready", int'(result_ready), int'(!m_full));
    check("stale", int'(stale), int'(m_cnt >= STALE_FRAMES));
    check("draw_on", int'(draw_on), int'(exp_draw));
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, '0, 0, 0);
  endtask

  task automatic pix_check(string name, int px, int py, int want);
    cycle(1'b0, 1'b0, 1'b0, '0, px, py);
    cycle(1'b0, 1'b0, 1'b0, '0, 0, 0);
    check(name, int'(draw_on), want);
  endtask

  // Samples the centre of every glyph cell of every box and counts lit cells.
  task automatic scan(output int cnt);
    cnt = 0;
    idle(2);
    for (int d = 0; d < NUM_DIGITS; d++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 8; c++) begin
          cycle(1'b0, 1'b0, 1'b0, '0, START_X + d*PITCH + c*SCALE + SCALE/2,
                START_Y + r*SCALE + SCALE/2);
          cnt += int'(draw_on);
        end
    repeat (2) begin
      cycle(1'b0, 1'b0, 1'b0, '0, 0, 0);
      cnt += int'(draw_on);
    end
  endtask

  task automatic commit(logic [4*NUM_DIGITS-1:0] dig);
    cycle(1'b0, 1'b0, 1'b1, dig, 0, 0);
    cycle(1'b0, 1'b1, 1'b0, '0, 0, 0);
  endtask

  initial begin
    vec_t tbl [12];
    int   n;
    int   vrate;
    // Display "07" (box 0 blanked as a leading zero), SCALE 8: box 1 spans x 104..167, y 32..159.
    tbl = '{
      '{104,  32, 0}, '{112,  40, 1}, '{104,  40, 0}, '{160,  40, 0},
      '{152,  47, 1}, '{112,  48, 1}, '{128,  48, 0}, '{ 40,  48, 0},
      '{168,  40, 0}, '{120, 120, 1}, '{120, 159, 0}, '{120, 160, 0}
    };
    foreach (m_disp[d]) begin
      m_disp[d] = 15;
      m_pend[d] = 0;
    end

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, '0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, '0, 0, 0);
    check("rst_ready", int'(result_ready), 1);
    check("rst_stale", int'(stale), 0);
    check("rst_draw", int'(draw_on), 0);

    // Offer 0x07, commit, then pipeline lag and pixel table
    cycle(1'b0, 1'b0, 1'b1, 8'h07, 0, 0);
    check("ready_fall", int'(result_ready), 0);
    cycle(1'b0, 1'b1, 1'b0, '0, 0, 0);
    check("ready_after_commit", int'(result_ready), 1);
    cycle(1'b0, 1'b0, 1'b0, '0, 112, 40);
    check("lag_1cyc", int'(draw_on), 0);
    cycle(1'b0, 1'b0, 1'b0, '0, 0, 0);
    check("lag_2cyc", int'(draw_on), 1);
    cycle(1'b0, 1'b0, 1'b0, '0, 0, 0);
    check("lag_3cyc", int'(draw_on), 0);
    foreach (tbl[i]) pix_check($sformatf("tbl%0d", i), tbl[i].px, tbl[i].py, tbl[i].want);

    // Backpressure: 0x42 pending, 0x13 held until a frame_start drains pending
    cycle(1'b0, 1'b0, 1'b1, 8'h42, 0, 0);
    check("ready_full", int'(result_ready), 0);
    result_valid = 1'b1; result_digits = 8'h13; #1;
    check("ready_no_comb", int'(result_ready), 0);
    cycle(1'b0, 1'b0, 1'b1, 8'h13, 0, 0);
    check("hold_not_taken", int'(result_ready), 0);
    cycle(1'b0, 1'b1, 1'b1, 8'h13, 0, 0);
    check("ready_after_fs", int'(result_ready), 1);
    cycle(1'b0, 1'b0, 1'b1, 8'h13, 0, 0);
    check("second_taken", int'(result_ready), 0);
    // "4" row 6 is fully lit: box edges at x=32 and x=95, gap from x=96
    pix_check("b0_last", 95, 80, 1);
    pix_check("gap_first", 96, 80, 0);
    pix_check("b0_first", 32, 80, 1);
    pix_check("before_b0", 31, 80, 0);

    // Transfer in the same cycle as frame_start
    cycle(1'b0, 1'b1, 1'b0, '0, 0, 0);
    cycle(1'b0, 1'b1, 1'b1, 8'h56, 0, 0);
    check("same_cycle_pending", int'(result_ready), 0);
    pix_check("old_frame", 40, 40, 0);
    cycle(1'b0, 1'b1, 1'b0, '0, 0, 0);
    pix_check("new_frame", 40, 40, 1);

    // Stale timeout after three empty frames, cleared by a commit
    cycle(1'b0, 1'b1, 1'b0, '0, 0, 0);
    check("stale_fs1", int'(stale), 0);
    cycle(1'b0, 1'b1, 1'b0, '0, 0, 0);
    check("stale_fs2", int'(stale), 0);
    cycle(1'b0, 1'b1, 1'b0, '0, 0, 0);
    check("stale_fs3", int'(stale), 1);
    scan(n);
    check("minus_count", n, 24);
    commit(8'h09);
    check("stale_clear", int'(stale), 0);

    // Blank codes and lit-cell counts of known glyphs
    commit(8'hBF); scan(n); check("blank_bf", n, 0);
    commit(8'hDE); scan(n); check("blank_de", n, 0);
    commit(8'h08); scan(n); check("scan_08", n, 44);
    commit(8'h80); scan(n); check("scan_80", n, 94);
    commit(8'h00); scan(n); check("scan_00", n, 50);

    // Reset mid-frame with pending full, on a lit pixel
    cycle(1'b0, 1'b0, 1'b1, 8'h88, 112, 48);
    check("pend_before_rst", int'(result_ready), 0);
    cycle(1'b1, 1'b1, 1'b1, 8'h77, 112, 48);
    check("rst2_ready", int'(result_ready), 1);
    check("rst2_stale", int'(stale), 0);
    check("rst2_draw", int'(draw_on), 0);
    cycle(1'b0, 1'b1, 1'b0, '0, 112, 48);
    check("rst2_draw_next", int'(draw_on), 0);
    scan(n);
    check("lost_pending", n, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit r, fs, v;
      int px, py;
      vrate = (i < 2000) ? 25 : 2;
      r  = ($urandom_range(0, 1499) == 0);
      fs = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 99) < vrate);
      if ($urandom_range(0, 9) < 8) begin
        px = $urandom_range(START_X - 8, START_X + 2*PITCH + 8);
        py = $urandom_range(START_Y - 8, START_Y + 16*SCALE + 8);
      end else begin
        px = $urandom_range(0, 1023);
        py = $urandom_range(0, 1023);
      end
      cycle(r, fs, v, 8'($urandom_range(0, 255)), px, py);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_digit_overlay.md
MULTI_DIGIT_OVERLAY -- requirements
Module: multi_digit_overlay

Interface
REQ-001 Parameter H_VISIBLE, default 640: visible width in pixels.
REQ-002 Parameter V_VISIBLE, default 480: visible height in pixels.
REQ-003 Parameter NUM_DIGITS, default 2: digit count; legal range 1..4.
REQ-004 Parameter SCALE, default 4: glyph magnification; legal values 1, 2, 4, 8.
REQ-005 Parameter START_X, default 32 / START_Y, default 32: top-left corner of the leftmost digit box.
REQ-006 Parameter DIGIT_GAP, default 8: blank screen pixels between adjacent digit boxes.
REQ-007 Parameter STALE_FRAMES, default 60: frames without a new result before the display goes stale; legal range 1..255.
REQ-008 Parameter LZ_BLANK, default 1: 1 = suppress leading zeros; the rightmost digit is never suppressed.
REQ-009 clk  in  1  pixel clock; single clock domain.
REQ-010 rst  in  1  reset; synchronous, active-high.
REQ-011 x  in  10  current pixel column.
REQ-012 y  in  10  current pixel row.
REQ-013 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-014 result_valid  in  1  new result offered.
REQ-015 result_ready  out  1  block can accept a result.
REQ-016 result_digits  in  4*NUM_DIGITS  BCD codes; the MS nibble is the leftmost digit.
REQ-017 draw_on  out  1  current pixel is a glyph pixel.
REQ-018 stale  out  1  displayed result has aged out.

Function
REQ-019 A result SHALL be transferred on any cycle where result_valid and result_ready are both 1, and it SHALL be stored in a pending register.
REQ-020 result_ready SHALL be 1 whenever the pending register is empty and 0 while it holds data; result_ready SHALL NOT depend combinationally on result_valid.
REQ-021 On frame_start with pending full, the block SHALL copy pending into the display register, empty pending, and clear the stale counter and stale.
REQ-022 On frame_start with pending empty, the stale counter SHALL increment, saturating at STALE_FRAMES, and stale SHALL be 1 once the counter equals STALE_FRAMES.
REQ-023 If a transfer and frame_start occur in the same cycle with pending empty, the new result SHALL go to pending and SHALL be committed at the next frame_start, not the current one.
REQ-024 The display register SHALL change only on frame_start, so no frame ever shows a mixed result.
REQ-025 Digit box k (k = 0..NUM_DIGITS-1) SHALL span x in [START_X + k*(8*SCALE+DIGIT_GAP), +8*SCALE) and y in [START_Y, START_Y+16*SCALE).
REQ-026 Glyph column = offset_x >> log2(SCALE); glyph row = offset_y >> log2(SCALE); no divider SHALL be inferred.
REQ-027 Glyph source is the team standard 8x16 digit font, with rows 0 and 15 blank and bit 7 as the leftmost column.
REQ-028 Codes 0-9 SHALL draw digits, code 0xA SHALL draw a minus glyph (rows 7-8 = 8'h7E), and codes 0xB-0xF SHALL draw blank.
REQ-029 With LZ_BLANK=1, any zero digit left of the first nonzero digit SHALL be drawn blank, except the rightmost digit.
REQ-030 While stale=1, every digit box SHALL draw the minus glyph regardless of the display register.
REQ-031 draw_on SHALL be a 2-stage pipeline: stage 1 registers box hit, digit index, glyph row and glyph column; stage 2 registers the font bit. draw_on at cycle n+2 SHALL reflect x,y at cycle n.
REQ-032 Pixels outside all boxes, or with x >= H_VISIBLE or y >= V_VISIBLE, SHALL give draw_on = 0.
REQ-033 Box arithmetic SHALL use 11-bit unsigned intermediates so that START_X + extent does not wrap.

Reset
REQ-034 On rst the block SHALL set pending empty, result_ready=1, every display code = 0xF (blank), stale counter = 0, stale = 0, and both pipeline stages and draw_on = 0.
REQ-035 rst SHALL win over simultaneous frame_start or a transfer, and the result offered in that cycle SHALL be dropped.
REQ-036 From the first cycle after rst is deasserted the block SHALL operate normally, and draw_on SHALL stay 0 until the first commit or the stale timeout.

Verification
REQ-037 Reset, then offer digits 0x07 with NUM_DIGITS=2: result_ready falls the next cycle; after frame_start a "7" appears in box 1, box 0 stays blank (LZ), and draw_on lags x,y by exactly 2 cycles.
REQ-038 Offer 0x42, hold result_valid with a second value 0x13 while pending is full: ready=0 and 0x13 is not taken; frame_start displays "42"; 0x13 transfers the next cycle.
REQ-039 Transfer and frame_start in the same cycle: the old value stays for that frame and the new value appears after the following frame_start.
REQ-040 STALE_FRAMES=3, no new results: stale rises on the 3rd frame_start after a commit, both boxes show the minus glyph, and the next commit clears stale.
REQ-041 SCALE=8, x = START_X+8*SCALE-1 and START_X+8*SCALE: the last pixel is in box 0 and the next pixel is in the gap (draw_on = 0). Codes 0xB-0xF draw blank.
REQ-042 Assert rst mid-frame with pending full: all outputs return to their reset values the next cycle, and the pending result is lost.
